fifo_stim_gen: RTL
==================

# fifo_stim_gen

Self-contained traffic generator that drives the write/read request side of a FIFO under test. It is the producing end of the FIFO self-check path: it issues `wq`/`rq` strobes and `wr_data` in a fixed phase sequence while the FIFO checker compares the read data. It tracks its own occupancy so it never overflows or underflows the FIFO, and reports completion and transfer counts.

## Interface
- `DATA_W`, 8, write data width
- `PTR_W`, 4, FIFO pointer width; DEPTH = 2**PTR_W
- `MIX_LEN`, 64, cycles spent in the mixed phase (≥1)
- `clk` in 1 system clock, rising edge
- `rst_n` in 1 asynchronous, active-low reset
- `start` in 1 one-cycle pulse; begins a sequence when idle
- `full` in 1 FIFO full flag
- `empty` in 1 FIFO empty flag
- `wq` out 1 write strobe, registered
- `rq` out 1 read strobe, registered
- `wr_data` out DATA_W write data, valid when `wq`=1
- `busy` out 1 high from the cycle after the accepted `start` until `done`
- `done` out 1 one-cycle pulse at sequence end
- `wr_cnt` out 16 writes issued this sequence (saturates at 16'hFFFF)
- `rd_cnt` out 16 reads issued this sequence (saturates)

## Operation
- States: IDLE → FILL → DRAIN → MIX → FLUSH → FIN → IDLE.
- IDLE: `start`=1 clears `wr_cnt`, `rd_cnt`, occupancy `occ` and the data pattern, then enters FILL. `start` outside IDLE is ignored.
- FILL: `wq`=1 each cycle where `occ`<DEPTH and `full`=0. Enter DRAIN after DEPTH writes.
- DRAIN: `rq`=1 each cycle where `occ`>0 and `empty`=0. Enter MIX when `occ`=0.
- MIX: runs for exactly MIX_LEN cycles. A gating LFSR (8-bit, x^8+x^6+x^5+x^4+1, seed 8'hA5, steps every MIX cycle) sets the requests. Bit0 requests a write and bit1 requests a read. Each request is still gated by the `occ` and full/empty rules, and both may issue in the same cycle.
- FLUSH: read as in DRAIN until `occ`=0.
- FIN: `done`=1 for one cycle, `busy`=0, then IDLE.
- `occ` is width PTR_W+1. It changes +1 on a write only, −1 on a read only, and is unchanged on a simultaneous write and read.
- A read is never issued in the same cycle as the write that makes `occ` nonzero, because `occ` is sampled before the update.
- `wr_data` follows the data pattern. The pattern advances only on an issued write and wraps modulo 2**DATA_W.
- Counters saturate and do not wrap.

## Timing
- Reset values: `wq`=0, `rq`=0, `wr_data`=0, `busy`=0, `done`=0, `wr_cnt`=0, `rd_cnt`=0. State is IDLE and the LFSR holds 8'hA5.
- `full`/`empty` are sampled at edge N and the strobe appears after edge N, lasting one cycle.
- First `wq` comes 2 cycles after the `start` pulse: one cycle for IDLE→FILL, one for the registered output.
- Read data returns from the FIFO one cycle after `rq`. That is the checker's concern; the generator only drives strobes.
- Reset asserted mid-sequence returns every output to its reset value immediately. No `done` is generated.
- If `full` or `empty` disagrees with `occ`, the more restrictive condition wins and the generator stalls, still in the same state.

## Configuration
- `FIFO_STIM_LFSR_EN` defined: `wr_data` comes from a DATA_W-bit Galois LFSR, seed all-ones, stepping per issued write. The first written word is all-ones.
- `FIFO_STIM_LFSR_EN` undefined: `wr_data` is an incrementing count starting at 0.
- The gating LFSR in MIX is present in both builds.

## Structure
- `fifo_stim_pkg` holds:
  - the state enum (IDLE, FILL, DRAIN, MIX, FLUSH, FIN);
  - the gating LFSR seed and taps;
  - the counter width constant (16).
- Sub-module `stim_lfsr`, parameterised on width, taps and seed, with a step enable. It is instantiated for gating, and for data when `FIFO_STIM_LFSR_EN` is defined.

## Test plan
- Reset, then `start` with `full`=`empty`=0 and a FIFO model attached, DEPTH=16 → 16 `wq`, then 16 `rq`. In the incrementing build, `wr_data` runs 0..15.
- Hold `full`=1 for 5 cycles mid-FILL → `wq` pauses exactly those cycles; the total is still 16 writes before DRAIN.
- Full sequence with MIX_LEN=64 → `done` pulses once and `wr_cnt`==`rd_cnt`. `occ` never exceeds 16 and never goes below 0.
- Assert `rst_n`=0 during MIX → next cycle `wq`=`rq`=`busy`=0, no `done`. A later `start` restarts from FILL with `wr_data`=0.
- `start` pulsed while `busy`=1 → ignored: a single `done`, counters not cleared.
- LFSR build → first `wr_data`=all-ones, and the sequence matches the reference LFSR model for 32 writes.

Source files
------------

// File: rtl/fifo_stim_pkg.sv
// Shared types and constants for the FIFO stimulus generator.
// Tap masks are right-shift Galois form: bit k set means x^(k+1) is in the polynomial.
package fifo_stim_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StDrain,
        StMix,
        StFlush,
        StFin
    } stim_state_e;

    // Gating LFSR: x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [7:0] GateSeed = 8'hA5;
    localparam logic [7:0] GateTaps = 8'hB8;

    localparam int unsigned CntW = 16;

    // Maximal-length tap masks for the data LFSR, indexed by width.
    function automatic logic [31:0] lfsr_taps(int unsigned width);
        case (width)
            4:       return 32'h0000_000C;
            5:       return 32'h0000_0014;
            6:       return 32'h0000_0030;
            7:       return 32'h0000_0060;
            8:       return 32'h0000_00B8;
            10:      return 32'h0000_0240;
            12:      return 32'h0000_0E08;
            16:      return 32'h0000_B400;
            24:      return 32'h00E1_0000;
            32:      return 32'h8020_0003;
            default: return 32'h0000_00B8;
        endcase
    endfunction

endpackage

// File: rtl/fifo_stim_gen_if.sv
// FIFO request-side bundle: strobes and write data out of the generator,
// full/empty flags back from the FIFO under test.
interface fifo_stim_gen_if #(
    parameter int unsigned DATA_W = 8
);
    logic              wq;
    logic              rq;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;

    modport master (output wq, rq, wr_data, input full, empty);
    modport slave  (input wq, rq, wr_data, output full, empty);
endinterface

// File: rtl/stim_lfsr.sv
// Right-shift Galois LFSR with synchronous reload and step enable.
module stim_lfsr #(
    parameter int unsigned      Width = 8,
    parameter logic [Width-1:0] Taps  = '1,
    parameter logic [Width-1:0] Seed  = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    output logic [Width-1:0] value
);

    logic [Width-1:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (load) begin
            lfsr_d = Seed;
        end else if (step) begin
            lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? Taps : '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= Seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign value = lfsr_q;

endmodule

// File: rtl/fifo_stim_gen.sv
// FIFO traffic generator: FILL, DRAIN, LFSR-gated MIX, FLUSH, then a done pulse.
// Define FIFO_STIM_LFSR_EN for LFSR write data instead of an incrementing count.
module fifo_stim_gen
    import fifo_stim_pkg::*;
#(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned PTR_W   = 4,
    parameter int unsigned MIX_LEN = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    fifo_stim_gen_if.master         bus,
    output logic                    busy,
    output logic                    done,
    output logic [CntW-1:0]         wr_cnt,
    output logic [CntW-1:0]         rd_cnt
);

    localparam int unsigned     Depth   = 2 ** PTR_W;
    localparam logic [PTR_W:0]  OccFull = (PTR_W + 1)'(Depth);
    localparam int unsigned     MixW    = (MIX_LEN > 1) ? $clog2(MIX_LEN) : 1;
    localparam logic [MixW-1:0] MixLast = MixW'(MIX_LEN - 1);

    stim_state_e       state_q, state_d;
    logic [PTR_W:0]    occ_q, occ_d;
    logic [MixW-1:0]   mix_q, mix_d;
    logic [CntW-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic              wq_q, rq_q;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              wr_en, rd_en, seq_start, gate_step;
    logic              can_wr, can_rd;
    logic [7:0]        gate_val;
    logic [DATA_W-1:0] pat_val;
    logic              unused_gate_bits;

    // Flags and local occupancy must both allow a request; the stricter one wins.
    assign can_wr = (occ_q < OccFull) && !bus.full;
    assign can_rd = (occ_q != '0) && !bus.empty;

    // Gating sequence is reseeded at each start so every sequence is repeatable.
    stim_lfsr #(
        .Width (8),
        .Taps  (GateTaps),
        .Seed  (GateSeed)
    ) u_gate_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (seq_start),
        .step  (gate_step),
        .value (gate_val)
    );

    assign unused_gate_bits = ^gate_val[7:2];

`ifdef FIFO_STIM_LFSR_EN
    stim_lfsr #(
        .Width (DATA_W),
        .Taps  (DATA_W'(lfsr_taps(DATA_W))),
        .Seed  ({DATA_W{1'b1}})
    ) u_data_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (seq_start),
        .step  (wr_en),
        .value (pat_val)
    );
`else
    logic [DATA_W-1:0] pat_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pat_q <= '0;
        end else if (seq_start) begin
            pat_q <= '0;
        end else if (wr_en) begin
            pat_q <= pat_q + 1'b1;
        end
    end

    assign pat_val = pat_q;
`endif

    always_comb begin
        state_d   = state_q;
        mix_d     = mix_q;
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        seq_start = 1'b0;
        gate_step = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    seq_start = 1'b1;
                    mix_d     = '0;
                    state_d   = StFill;
                end
            end
            StFill:           wr_en = can_wr;
            StDrain, StFlush: rd_en = can_rd;
            StMix: begin
                wr_en     = gate_val[0] && can_wr;
                rd_en     = gate_val[1] && can_rd;
                gate_step = 1'b1;
                mix_d     = mix_q + 1'b1;
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase

        occ_d = occ_q;
        if (seq_start) begin
            occ_d = '0;
        end else if (wr_en && !rd_en) begin
            occ_d = occ_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            occ_d = occ_q - 1'b1;
        end

        // Phase exits look at post-update occupancy so no idle cycle is inserted.
        case (state_q)
            StFill:  if (occ_d == OccFull) state_d = StDrain;
            StDrain: if (occ_d == '0) state_d = StMix;
            StMix:   if (mix_q == MixLast) state_d = StFlush;
            StFlush: if (occ_d == '0) state_d = StFin;
            default: ;
        endcase
    end

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        wr_data_d = wr_data_q;
        if (seq_start) begin
            wr_cnt_d = '0;
            rd_cnt_d = '0;
        end else begin
            if (wr_en && (wr_cnt_q != '1)) wr_cnt_d = wr_cnt_q + 1'b1;
            if (rd_en && (rd_cnt_q != '1)) rd_cnt_d = rd_cnt_q + 1'b1;
        end
        if (wr_en) wr_data_d = pat_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            occ_q     <= '0;
            mix_q     <= '0;
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            wq_q      <= 1'b0;
            rq_q      <= 1'b0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            occ_q     <= occ_d;
            mix_q     <= mix_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            wq_q      <= wr_en;
            rq_q      <= rd_en;
            wr_data_q <= wr_data_d;
        end
    end

    assign bus.wq      = wq_q;
    assign bus.rq      = rq_q;
    assign bus.wr_data = wr_data_q;
    assign busy        = (state_q == StFill) || (state_q == StDrain) ||
                         (state_q == StMix)  || (state_q == StFlush);
    assign done        = (state_q == StFin);
    assign wr_cnt      = wr_cnt_q;
    assign rd_cnt      = rd_cnt_q;

endmodule
